// File: rtl/aes_stream_bridge.sv
// ----------------------------------------------------------------------------
// aes_stream_bridge
//   Bridges a framed host byte stream to an AES core over valid/ready.
//   A frame is one header byte followed by FRAME_BYTES payload bytes. The
//   header carries the opcode in bits [1:0] and the source ID in the top
//   SRC_W bits. Payload is forwarded to the core from an input FIFO. Core
//   results are tagged with the in-flight source ID and returned through an
//   output FIFO. A frame completes on the core's ack handshake.
//
// Configuration macro:
//   AES_BRIDGE_TIMEOUT_EN - when defined, a 16-bit gap counter drops a frame
//                           whose payload stalls for 0xFFFF cycles. Port list
//                           is identical either way.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   h_data_in/h_valid_in/h_ready_out    host -> input FIFO
//   h_data_out/h_src_out/h_valid_out/h_ready_in   output FIFO -> host
//   c_data_out/c_valid_out/c_ready_in   payload -> core
//   c_data_in/c_valid_in/c_ready_out    core result -> output FIFO
//   c_ack_valid/c_ack_ready             core frame-done handshake
//   c_src_id                     source ID of the in-flight frame
//   busy                         FSM not idle
//   frame_err                    sticky error flag
// ----------------------------------------------------------------------------

// Register-array FIFO with first-word-fall-through head.
//   i_push/i_data  write request (ignored when full)
//   i_pop          read request (ignored when empty)
//   o_data         current head
//   o_full/o_empty status from the registered count
module aes_stream_bridge_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; reads are gated by the empty flag downstream.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

module aes_stream_bridge #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned IN_DEPTH    = 16,
    parameter int unsigned OUT_DEPTH   = 16,
    parameter int unsigned FRAME_BYTES = 16,
    parameter int unsigned SRC_W       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] h_data_in,
    input  logic              h_valid_in,
    output logic              h_ready_out,
    output logic [DATA_W-1:0] h_data_out,
    output logic [SRC_W-1:0]  h_src_out,
    output logic              h_valid_out,
    input  logic              h_ready_in,
    output logic [DATA_W-1:0] c_data_out,
    output logic              c_valid_out,
    input  logic              c_ready_in,
    input  logic [DATA_W-1:0] c_data_in,
    input  logic              c_valid_in,
    output logic              c_ready_out,
    input  logic              c_ack_valid,
    output logic              c_ack_ready,
    output logic [SRC_W-1:0]  c_src_id,
    output logic              busy,
    output logic              frame_err
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned OW    = SRC_W + DATA_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HDR      = 2'd1,
        S_PAYLOAD  = 2'd2,
        S_WAIT_ACK = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SRC_W-1:0]  r_src;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_frame_err;
    logic              r_run;

    logic [DATA_W-1:0] w_in_head;
    logic              w_in_full;
    logic              w_in_empty;
    logic              w_in_push;
    logic              w_in_pop;
    logic [OW-1:0]     w_out_head;
    logic              w_out_full;
    logic              w_out_empty;
    logic              w_out_push;
    logic              w_out_pop;

    logic [1:0]        w_hdr_op;
    logic              w_hdr_fire;
    logic              w_pay_xfer;
    logic              w_last;
    logic              w_stray_ack;
    logic              w_drop;
    logic              w_timeout;

    // ---------------- input path ----------------
    // r_run holds both readies low while in reset and for one cycle after.
    assign h_ready_out = r_run & ~w_in_full;
    assign w_in_push   = h_valid_in & h_ready_out;

    aes_stream_bridge_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_in_push),
        .i_data  (h_data_in),
        .i_pop   (w_in_pop),
        .o_data  (w_in_head),
        .o_full  (w_in_full),
        .o_empty (w_in_empty)
    );

    // ---------------- result path (independent of FSM) ----------------
    assign c_ready_out = r_run & ~w_out_full;
    assign w_out_push  = c_valid_in & c_ready_out;
    assign h_valid_out = ~w_out_empty;
    assign w_out_pop   = h_valid_out & h_ready_in;
    assign h_data_out  = h_valid_out ? w_out_head[DATA_W-1:0] : '0;
    assign h_src_out   = h_valid_out ? w_out_head[OW-1 -: SRC_W] : '0;

    aes_stream_bridge_fifo #(
        .WIDTH (OW),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_out_push),
        .i_data  ({r_src, c_data_in}),
        .i_pop   (w_out_pop),
        .o_data  (w_out_head),
        .o_full  (w_out_full),
        .o_empty (w_out_empty)
    );

    // ---------------- control decode ----------------
    assign w_hdr_op    = w_in_head[1:0];
    assign w_hdr_fire  = (r_state == S_HDR) & ~w_in_empty;
    // While dropping, buffered bytes are consumed without core handshake.
    assign w_pay_xfer  = (r_state == S_PAYLOAD) & ~w_in_empty & (w_drop | c_ready_in);
    assign w_last      = (r_cnt == LAST_IDX);
    assign w_stray_ack = c_ack_valid & (r_state != S_WAIT_ACK);

`ifdef AES_BRIDGE_TIMEOUT_EN
    localparam int unsigned GAP_W = 16;
    localparam logic [GAP_W-1:0] GAP_MAX = {GAP_W{1'b1}};

    logic [GAP_W-1:0] r_gap;
    logic             r_drop;

    assign w_drop    = r_drop;
    assign w_timeout = (r_state == S_PAYLOAD) & ~r_drop & ~w_pay_xfer & (r_gap == GAP_MAX);

    // Gap counter: stalled payload cycles; switches to drop mode at saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap  <= '0;
            r_drop <= 1'b0;
        end else if ((r_state != S_PAYLOAD) || (w_state_nxt != S_PAYLOAD)) begin
            r_gap  <= '0;
            r_drop <= 1'b0;
        end else if (w_pay_xfer || r_drop) begin
            r_gap  <= '0;
        end else if (w_timeout) begin
            r_gap  <= '0;
            r_drop <= 1'b1;
        end else begin
            r_gap  <= r_gap + GAP_W'(1);
        end
    end
`else
    assign w_drop    = 1'b0;
    assign w_timeout = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_in_empty) w_state_nxt = S_HDR;
            end
            S_HDR: begin
                if (!w_in_empty) w_state_nxt = w_hdr_op[1] ? S_IDLE : S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (w_pay_xfer && w_last) w_state_nxt = w_drop ? S_IDLE : S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (c_ack_valid) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        c_valid_out = 1'b0;
        c_data_out  = '0;
        c_ack_ready = 1'b0;
        w_in_pop    = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_HDR: begin
                w_in_pop = ~w_in_empty;
            end
            S_PAYLOAD: begin
                c_valid_out = ~w_in_empty & ~w_drop;
                c_data_out  = c_valid_out ? w_in_head : '0;
                w_in_pop    = w_pay_xfer;
            end
            S_WAIT_ACK: begin
                c_ack_ready = 1'b1;
            end
            default: begin
                w_in_pop = 1'b0;
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    // Error set sources are evaluated last so they win over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src       <= '0;
            r_cnt       <= '0;
            r_frame_err <= 1'b0;
            r_run       <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_hdr_fire && !w_hdr_op[1]) begin
                r_src <= w_in_head[DATA_W-1 -: SRC_W];
                r_cnt <= '0;
            end else if (w_pay_xfer) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_hdr_fire && (w_hdr_op == 2'b11)) r_frame_err <= 1'b0;
            if ((w_hdr_fire && (w_hdr_op == 2'b10)) || w_stray_ack || w_timeout)
                r_frame_err <= 1'b1;
        end
    end

    assign c_src_id  = r_src;
    assign frame_err = r_frame_err;
endmodule

// File: tb/tb_aes_stream_bridge.sv
// Self-checking bench for aes_stream_bridge (default parameters).
module tb_aes_stream_bridge;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] h_data_in;
    logic       h_valid_in;
    logic       h_ready_out;
    logic [7:0] h_data_out;
    logic [1:0] h_src_out;
    logic       h_valid_out;
    logic       h_ready_in;
    logic [7:0] c_data_out;
    logic       c_valid_out;
    logic       c_ready_in;
    logic [7:0] c_data_in;
    logic       c_valid_in;
    logic       c_ready_out;
    logic       c_ack_valid;
    logic       c_ack_ready;
    logic [1:0] c_src_id;
    logic       busy;
    logic       frame_err;

    logic [26:0] all_out;
    assign all_out = {h_ready_out, h_valid_out, h_data_out, h_src_out, c_valid_out,
                      c_data_out, c_ready_out, c_ack_ready, c_src_id, busy, frame_err};

    int n_vec = 0;
    int n_err = 0;
    logic [9:0] exp_core_q[$];
    logic [9:0] exp_host_q[$];

    always #5 clk = ~clk;

    aes_stream_bridge #(
        .DATA_W(8), .IN_DEPTH(16), .OUT_DEPTH(16), .FRAME_BYTES(16), .SRC_W(2)
    ) dut (
        .clk(clk), .rst(rst),
        .h_data_in(h_data_in), .h_valid_in(h_valid_in), .h_ready_out(h_ready_out),
        .h_data_out(h_data_out), .h_src_out(h_src_out), .h_valid_out(h_valid_out),
        .h_ready_in(h_ready_in),
        .c_data_out(c_data_out), .c_valid_out(c_valid_out), .c_ready_in(c_ready_in),
        .c_data_in(c_data_in), .c_valid_in(c_valid_in), .c_ready_out(c_ready_out),
        .c_ack_valid(c_ack_valid), .c_ack_ready(c_ack_ready), .c_src_id(c_src_id),
        .busy(busy), .frame_err(frame_err)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    // Scoreboard consumer: every handshake on either output pops an expectation.
    task automatic run_monitor();
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!rst && c_valid_out && c_ready_in) begin
                n_vec++;
                if (exp_core_q.size() == 0) begin
                    n_err++;
                    $display("FAIL core_byte unexpected: got src=%0d data=%h, expected nothing", c_src_id, c_data_out);
                end else begin
                    e = exp_core_q.pop_front();
                    if ({c_src_id, c_data_out} !== e) begin
                        n_err++;
                        $display("FAIL core_byte: got src=%0d data=%h, expected src=%0d data=%h",
                                 c_src_id, c_data_out, e[9:8], e[7:0]);
                    end
                end
            end
            if (!rst && h_valid_out && h_ready_in) begin
                n_vec++;
                if (exp_host_q.size() == 0) begin
                    n_err++;
                    $display("FAIL host_byte unexpected: got src=%0d data=%h, expected nothing", h_src_out, h_data_out);
                end else begin
                    e = exp_host_q.pop_front();
                    if ({h_src_out, h_data_out} !== e) begin
                        n_err++;
                        $display("FAIL host_byte: got src=%0d data=%h, expected src=%0d data=%h",
                                 h_src_out, h_data_out, e[9:8], e[7:0]);
                    end
                end
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one host byte; returns one step after the accepting edge.
    task automatic host_send(input logic [7:0] b);
        int k;
        k = 0;
        h_data_in  = b;
        h_valid_in = 1'b1;
        @(negedge clk);
        while (!h_ready_out && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) begin
            n_vec++;
            n_err++;
            $display("FAIL host_send_stall: h_ready_out=%b, expected 1", h_ready_out);
        end
        @(posedge clk);
        #1;
        h_valid_in = 1'b0;
    endtask

    // Drives one core result; the expected tagged byte is queued at handshake.
    task automatic core_send(input logic [7:0] b, input logic [1:0] src);
        int k;
        k = 0;
        c_data_in  = b;
        c_valid_in = 1'b1;
        @(negedge clk);
        while (!c_ready_out && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) begin
            n_vec++;
            n_err++;
            $display("FAIL core_send_stall: c_ready_out=%b, expected 1", c_ready_out);
        end
        exp_host_q.push_back({src, b});
        @(posedge clk);
        #1;
        c_valid_in = 1'b0;
    endtask

    task automatic wait_ack_ready(output bit ok);
        int k;
        k = 0;
        while (!c_ack_ready && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        ok = c_ack_ready;
    endtask

    task automatic send_ack();
        c_ack_valid = 1'b1;
        @(posedge clk);
        #1;
        c_ack_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        h_data_in = '0; h_valid_in = 1'b0; h_ready_in = 1'b1;
        c_ready_in = 1'b0; c_data_in = '0; c_valid_in = 1'b0; c_ack_valid = 1'b0;
        wait_cycles(3);
        n_vec++;
        if (all_out !== 27'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, expected 0", all_out);
        end
        rst = 1'b0;
        wait_cycles(2);
        n_vec++;
        if ({h_ready_out, c_ready_out, busy, frame_err} !== 4'b1100) begin
            n_err++;
            $display("FAIL reset_release: got %b, expected 1100", {h_ready_out, c_ready_out, busy, frame_err});
        end
    endtask

    task automatic test_basic_frame();
        bit ok;
        c_ready_in = 1'b1;
        for (int i = 0; i < 16; i++) exp_core_q.push_back({2'd1, 8'(i)});
        host_send(8'h40);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL latency_t1: busy=%b, expected 0", busy);
        end
        host_send(8'h00);
        n_vec++;
        if ({busy, c_valid_out} !== 2'b10) begin
            n_err++;
            $display("FAIL latency_t2: busy,c_valid_out=%b, expected 10", {busy, c_valid_out});
        end
        host_send(8'h01);
        n_vec++;
        if ({c_valid_out, c_data_out, c_src_id} !== {1'b1, 8'h00, 2'd1}) begin
            n_err++;
            $display("FAIL latency_t3: valid=%b data=%h src=%0d, expected 1 00 1", c_valid_out, c_data_out, c_src_id);
        end
        for (int i = 2; i < 16; i++) host_send(8'(i));
        wait_ack_ready(ok);
        n_vec++;
        if (!ok || exp_core_q.size() != 0) begin
            n_err++;
            $display("FAIL basic_wait_ack: ack_ready=%b left=%0d, expected 1 and 0", ok, exp_core_q.size());
        end
    endtask

    task automatic test_result_tagging();
        int k;
        fork
            begin
                for (int i = 0; i < 16; i++) core_send(8'hA0 + 8'(i), 2'd1);
            end
            begin
                for (int j = 0; j < 60; j++) begin
                    @(posedge clk);
                    #1;
                    h_ready_in = ~h_ready_in;
                end
            end
        join
        h_ready_in = 1'b1;
        k = 0;
        while ((exp_host_q.size() != 0 || h_valid_out) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_vec++;
        if (exp_host_q.size() != 0 || h_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL result_drain: left=%0d h_valid_out=%b, expected 0 0", exp_host_q.size(), h_valid_out);
        end
    endtask

    task automatic test_ack();
        n_vec++;
        if ({c_ack_ready, busy, frame_err} !== 3'b110) begin
            n_err++;
            $display("FAIL ack_pre: got %b, expected 110", {c_ack_ready, busy, frame_err});
        end
        send_ack();
        n_vec++;
        if ({c_ack_ready, busy, frame_err} !== 3'b000) begin
            n_err++;
            $display("FAIL ack_done: got %b, expected 000", {c_ack_ready, busy, frame_err});
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        c_ready_in = 1'b0;
        for (int i = 0; i < 16; i++) exp_core_q.push_back({2'd2, 8'h10 + 8'(i)});
        host_send(8'h80);
        for (int i = 0; i < 16; i++) host_send(8'h10 + 8'(i));
        n_vec++;
        if ({h_ready_out, c_valid_out, c_data_out, c_src_id} !== {1'b0, 1'b1, 8'h10, 2'd2}) begin
            n_err++;
            $display("FAIL full_state: ready=%b valid=%b data=%h src=%0d, expected 0 1 10 2",
                     h_ready_out, c_valid_out, c_data_out, c_src_id);
        end
        h_data_in  = 8'hEE;
        h_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_cycles(1);
            n_vec++;
            if (h_ready_out !== 1'b0) begin
                n_err++;
                $display("FAIL full_hold: h_ready_out=%b, expected 0", h_ready_out);
            end
        end
        h_valid_in = 1'b0;
        c_ready_in = 1'b1;
        wait_ack_ready(ok);
        n_vec++;
        if (!ok || exp_core_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_drain: ack_ready=%b left=%0d, expected 1 and 0", ok, exp_core_q.size());
        end
        send_ack();
        n_vec++;
        if ({busy, h_ready_out} !== 2'b01) begin
            n_err++;
            $display("FAIL bp_done: busy,ready=%b, expected 01", {busy, h_ready_out});
        end
    endtask

    task automatic test_errors();
        host_send(8'h02);
        wait_cycles(3);
        n_vec++;
        if ({frame_err, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL err_op10: err,busy=%b, expected 10", {frame_err, busy});
        end
        send_ack();
        n_vec++;
        if ({frame_err, busy, c_ack_ready} !== 3'b100) begin
            n_err++;
            $display("FAIL err_stray_ack_sticky: got %b, expected 100", {frame_err, busy, c_ack_ready});
        end
        host_send(8'h03);
        wait_cycles(3);
        n_vec++;
        if ({frame_err, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL err_clear: err,busy=%b, expected 00", {frame_err, busy});
        end
        send_ack();
        n_vec++;
        if (frame_err !== 1'b1) begin
            n_err++;
            $display("FAIL err_stray_ack_set: frame_err=%b, expected 1", frame_err);
        end
        host_send(8'h03);
        wait_cycles(3);
        n_vec++;
        if (frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear2: frame_err=%b, expected 0", frame_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        host_send(8'h02);
        wait_cycles(3);
        c_ready_in = 1'b1;
        for (int i = 0; i < 5; i++) exp_core_q.push_back({2'd1, 8'h20 + 8'(i)});
        host_send(8'h40);
        for (int i = 0; i < 5; i++) host_send(8'h20 + 8'(i));
        rst = 1'b1;
        #1;
        n_vec++;
        if (all_out !== 27'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: got %h, expected 0", all_out);
        end
        n_vec++;
        if (exp_core_q.size() != 2) begin
            n_err++;
            $display("FAIL midreset_forwarded: unsent=%0d, expected 2", exp_core_q.size());
        end
        exp_core_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cycles(2);
        n_vec++;
        if ({h_ready_out, c_ready_out, busy, frame_err, c_src_id} !== 6'b110000) begin
            n_err++;
            $display("FAIL midreset_release: got %b, expected 110000",
                     {h_ready_out, c_ready_out, busy, frame_err, c_src_id});
        end
        for (int i = 0; i < 16; i++) exp_core_q.push_back({2'd3, 8'h30 + 8'(i)});
        host_send(8'hC0);
        for (int i = 0; i < 16; i++) host_send(8'h30 + 8'(i));
        wait_ack_ready(ok);
        n_vec++;
        if (!ok || exp_core_q.size() != 0 || c_src_id !== 2'd3) begin
            n_err++;
            $display("FAIL midreset_frame: ack_ready=%b left=%0d src=%0d, expected 1 0 3",
                     ok, exp_core_q.size(), c_src_id);
        end
        send_ack();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_done: busy=%b, expected 0", busy);
        end
    endtask

`ifdef AES_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        bit ok;
        c_ready_in = 1'b1;
        for (int i = 0; i < 3; i++) exp_core_q.push_back({2'd0, 8'h50 + 8'(i)});
        host_send(8'h00);
        for (int i = 0; i < 3; i++) host_send(8'h50 + 8'(i));
        k = 0;
        while (frame_err !== 1'b1 && k < 70000) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_vec++;
        if (frame_err !== 1'b1 || k < 65000) begin
            n_err++;
            $display("FAIL timeout_err: frame_err=%b after %0d cycles, expected 1 after >=65000", frame_err, k);
        end
        for (int i = 0; i < 13; i++) host_send(8'h60 + 8'(i));
        wait_cycles(3);
        n_vec++;
        if ({busy, c_ack_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL timeout_drop: busy,ack_ready=%b, expected 00", {busy, c_ack_ready});
        end
        for (int i = 0; i < 16; i++) exp_core_q.push_back({2'd1, 8'h70 + 8'(i)});
        host_send(8'h40);
        for (int i = 0; i < 16; i++) host_send(8'h70 + 8'(i));
        wait_ack_ready(ok);
        n_vec++;
        if (!ok || exp_core_q.size() != 0) begin
            n_err++;
            $display("FAIL timeout_next_frame: ack_ready=%b left=%0d, expected 1 0", ok, exp_core_q.size());
        end
        send_ack();
    endtask
`endif

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_basic_frame();
        test_result_tagging();
        test_ack();
        test_backpressure();
        test_errors();
        test_reset_mid_frame();
`ifdef AES_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        wait_cycles(2);
        n_vec++;
        if (exp_core_q.size() != 0 || exp_host_q.size() != 0) begin
            n_err++;
            $display("FAIL final_queues: core=%0d host=%0d, expected 0 0", exp_core_q.size(), exp_host_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/aes_stream_bridge.md
Name: aes_stream_bridge

Overview:
- Parametrised successor to the fixed-wiring AES pin hookup.
- Accepts a framed byte stream from the host pins: one header byte followed by FRAME_BYTES payload bytes.
- Buffers input and output in FIFOs and forwards payload to the AES core over valid/ready.
- Returns core result bytes tagged with the frame's source ID and completes on the core's ack handshake.

Parameters:
- DATA_W, 8, byte-lane width of host and core data.
- IN_DEPTH, 16, input FIFO depth in words; power of two, >=2.
- OUT_DEPTH, 16, output FIFO depth in words; power of two, >=2.
- FRAME_BYTES, 16, payload words per frame; 1..255.
- SRC_W, 2, source-ID width; taken from header bits [DATA_W-1 -: SRC_W].

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- h_data_in  in  DATA_W  host byte.
- h_valid_in  in  1  host byte valid.
- h_ready_out  out  1  input FIFO not full.
- h_data_out  out  DATA_W  result byte to host.
- h_src_out  out  SRC_W  source ID of the current output byte.
- h_valid_out  out  1  output FIFO not empty.
- h_ready_in  in  1  host accepts result byte.
- c_data_out  out  DATA_W  payload byte to core.
- c_valid_out  out  1  payload byte valid.
- c_ready_in  in  1  core accepts payload.
- c_data_in  in  DATA_W  core result byte.
- c_valid_in  in  1  core result valid.
- c_ready_out  out  1  output FIFO not full.
- c_ack_valid  in  1  core signals frame done.
- c_ack_ready  out  1  bridge accepts ack.
- c_src_id  out  SRC_W  source ID of the in-flight frame.
- busy  out  1  FSM not in IDLE.
- frame_err  out  1  sticky error flag; cleared by reset or by a header with opcode 2'b11.

Behaviour:
- Reset (async assert, sync-style release): all outputs 0; FIFOs empty; FSM=IDLE; counters 0.
- Host transfer occurs when h_valid_in & h_ready_out; the byte is written to the input FIFO that cycle.
- Input FIFO is first-word-fall-through: the head is visible at the FSM the cycle after the write.
- FSM states: IDLE, HDR, PAYLOAD, WAIT_ACK.
- IDLE -> HDR when the input FIFO is non-empty.
- HDR pops one byte. Header bits [1:0] are the opcode:
  - 00 or 01: latch src = header[DATA_W-1 -: SRC_W], drive c_src_id, clear cnt, go to PAYLOAD.
  - 11: clear frame_err, go to IDLE.
  - 10: set frame_err, go to IDLE.
- PAYLOAD:
  - c_valid_out = input FIFO non-empty; c_data_out = FIFO head.
  - Each c_valid_out & c_ready_in pops the FIFO and increments cnt.
  - At cnt == FRAME_BYTES-1 with a transfer, go to WAIT_ACK.
- WAIT_ACK:
  - c_ack_ready = 1; c_ack_valid & c_ack_ready completes the frame -> IDLE.
  - c_ack_ready is 0 in every other state.
  - An ack in any state other than WAIT_ACK is ignored and sets frame_err.
- Result path is independent of the FSM:
  - c_valid_in & c_ready_out writes {c_src_id, c_data_in} to the output FIFO.
  - Host pops on h_valid_out & h_ready_in.
  - h_data_out and h_src_out show the FIFO head combinationally.
- Latency: header written at cycle t -> FSM in PAYLOAD at t+3 -> first c_valid_out at t+3 if payload is already buffered.
- FIFO boundaries:
  - Full: ready deasserts the same cycle count reaches DEPTH; a write into a full FIFO never occurs.
  - Simultaneous push and pop when full: allowed only if the pop makes room, i.e. ready is computed from the registered count, so no push occurs when full.
  - Simultaneous push and pop when empty: push only.
  - Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- Reset mid-frame: FSM returns to IDLE, both FIFOs flush, src clears; no partial frame is resumed.

Optional Feature:
- Macro: AES_BRIDGE_TIMEOUT_EN.
- Defined: a 16-bit gap counter runs in PAYLOAD and counts cycles with no payload transfer.
  - At 0xFFFF, drop the frame: set frame_err and discard the remaining FRAME_BYTES-cnt bytes as they arrive, without forwarding them to the core. The FSM does not enter WAIT_ACK; it returns to IDLE.
  - The counter resets on any transfer or on state exit.
- Undefined: no counter; PAYLOAD waits indefinitely. Port list is identical either way.

Test Plan:
- Basic frame: host sends 0x40 then payload 0x00..0x0F, core always ready -> c_src_id=1; 16 bytes 0x00..0x0F on c_data_out in order; FSM reaches WAIT_ACK; ack -> busy=0.
- Result tagging: in the frame above, core returns 0xA0..0xAF -> host reads 0xA0..0xAF with h_src_out=1, in order, with h_ready_in toggled every other cycle.
- Backpressure/full: c_ready_in=0, host pushes 17 bytes with IN_DEPTH=16 -> h_ready_out low after the 16th accepted write (header popped); no byte is lost or duplicated after c_ready_in=1.
- Errors: header 0x02 -> frame_err=1, FSM returns to IDLE; stray c_ack_valid in IDLE -> frame_err stays 1; header 0x03 -> frame_err=0.
- Reset mid-frame: assert rst after 5 payload bytes -> all outputs 0 immediately; next header 0xC0 plus 16 bytes -> clean frame with src=3.
- Timeout (macro defined): header 0x00 plus 3 bytes, then idle 65535 cycles -> frame_err=1; remaining 13 bytes are not forwarded; a subsequent frame completes normally.
